// File: rtl/serial_frame_receiver.sv
// Start/stop framed serial receiver: samples din on bit_en strobes and delivers
// each correctly framed WIDTH-bit word with valid, frame_err, match and a word count.
module serial_frame_receiver #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             din,
    // "expect" is a reserved SystemVerilog keyword, hence expect_word.
    input  logic [WIDTH-1:0] expect_word,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             frame_err,
    output logic             match,
    output logic [7:0]       word_cnt,
    output logic [3:0]       c_state,
    output logic [3:0]       n_state
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        DATA   = 4'd1,
        STOP   = 4'd2,
        RESYNC = 4'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        if (MSB_FIRST) shifted = {shreg[WIDTH-2:0], din};
        else           shifted = {din, shreg[WIDTH-1:1]};
    end

    always_comb begin
        // NOTE: default assignment first so every path drives next_state; no latch.
        next_state = state;
        case (state)
            IDLE:    if (bit_en && !din) next_state = DATA;
            DATA:    if (bit_en && bit_cnt == LAST_BIT) next_state = STOP;
            STOP:    if (bit_en) next_state = din ? IDLE : RESYNC;
            RESYNC:  if (bit_en && din) next_state = IDLE;
            // Illegal codes recover on the very next edge, strobe or not.
            default: next_state = IDLE;
        endcase
    end

    // NOTE: all state updates are non-blocking so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            dout      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            match     <= 1'b0;
            word_cnt  <= 8'd0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            state     <= next_state;
            if (bit_en) begin
                case (state)
                    IDLE: if (!din) bit_cnt <= '0;
                    DATA: begin
                        shreg   <= shifted;
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                    STOP: begin
                        if (din) begin
                            dout     <= shreg;
                            valid    <= 1'b1;
                            match    <= (shreg == expect_word);
                            word_cnt <= word_cnt + 8'd1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign c_state = state;
    assign n_state = next_state;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Bench for serial_frame_receiver: an MSB-first and an LSB-first instance share one line
// and are checked against a frame-level model of the expected words and counters.
module tb_serial_frame_receiver;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst    = 1'b1;
    logic bit_en = 1'b0;
    logic din    = 1'b1;

    logic [1:0][7:0] exp_w;
    logic [1:0][7:0] o_dout;
    logic [1:0]      o_valid;
    logic [1:0]      o_ferr;
    logic [1:0]      o_match;
    logic [1:0][7:0] o_cnt;
    logic [1:0][3:0] o_cs;
    logic [1:0][3:0] o_ns;

    // Model: index 0 = MSB-first instance, index 1 = LSB-first instance.
    logic [7:0] md_dout [2];
    logic       md_match[2];
    int         md_cnt  [2];

    int vpulses = 0;
    int epulses = 0;
    always @(negedge clk) begin
        if (o_valid[0]) vpulses++;
        if (o_ferr[0])  epulses++;
    end

    serial_frame_receiver #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .bit_en(bit_en), .din(din), .expect_word(exp_w[0]),
        .dout(o_dout[0]), .valid(o_valid[0]), .frame_err(o_ferr[0]), .match(o_match[0]),
        .word_cnt(o_cnt[0]), .c_state(o_cs[0]), .n_state(o_ns[0])
    );

    serial_frame_receiver #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .bit_en(bit_en), .din(din), .expect_word(exp_w[1]),
        .dout(o_dout[1]), .valid(o_valid[1]), .frame_err(o_ferr[1]), .match(o_match[1]),
        .word_cnt(o_cnt[1]), .c_state(o_cs[1]), .n_state(o_ns[1])
    );

    function automatic logic [7:0] reverse8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            md_dout[d]  = 8'h00;
            md_match[d] = 1'b0;
            md_cnt[d]   = 0;
        end
    endtask

    // One strobe; optionally checks n_state before the edge and quiet pulses after.
    task automatic strobe(input logic b, input int exp_ns, input bit quiet);
        din    = b;
        bit_en = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (o_ns[d] !== exp_ns[3:0]) begin
                errors++;
                $display("FAIL n_state dut%0d got %0d want %0d", d, o_ns[d], exp_ns);
            end
        end
        @(posedge clk);
        #1;
        bit_en = 1'b0;
        if (quiet) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (o_valid[d] !== 1'b0 || o_ferr[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL quiet_strobe dut%0d got valid=%b ferr=%b want 0 0",
                             d, o_valid[d], o_ferr[d]);
                end
            end
        end
    endtask

    // Non-strobe cycles with a noisy line: nothing may move.
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            din = 1'($urandom);
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (o_valid[d] !== 1'b0 || o_ferr[d] !== 1'b0 || o_ns[d] !== o_cs[d]) begin
                    errors++;
                    $display("FAIL idle dut%0d got valid=%b ferr=%b ns=%0d cs=%0d want 0 0 ns==cs",
                             d, o_valid[d], o_ferr[d], o_ns[d], o_cs[d]);
                end
            end
        end
    endtask

    // seq[7] is the first data bit on the line.
    task automatic send_frame(input logic [7:0] seq, input logic stop, input int gap);
        logic [7:0] word [2];
        word[0] = seq;
        word[1] = reverse8(seq);
        strobe(1'b0, 1, 1'b1);
        idle(gap);
        for (int i = 7; i >= 0; i--) begin
            strobe(seq[i], (i == 0) ? 2 : 1, 1'b1);
            idle(gap);
        end
        strobe(stop, stop ? 0 : 3, 1'b0);
        for (int d = 0; d < 2; d++) begin
            if (stop) begin
                md_dout[d]  = word[d];
                md_match[d] = (word[d] == exp_w[d]);
                md_cnt[d]   = (md_cnt[d] + 1) % 256;
            end
            checks++;
            if (o_valid[d] !== stop || o_ferr[d] !== !stop) begin
                errors++;
                $display("FAIL stop_pulse dut%0d got valid=%b ferr=%b want %b %b",
                         d, o_valid[d], o_ferr[d], stop, !stop);
            end
            checks++;
            if (o_dout[d] !== md_dout[d] || o_match[d] !== md_match[d] ||
                o_cnt[d] !== 8'(md_cnt[d])) begin
                errors++;
                $display("FAIL frame_out dut%0d got dout=%h match=%b cnt=%0d want %h %b %0d",
                         d, o_dout[d], o_match[d], o_cnt[d], md_dout[d], md_match[d], md_cnt[d]);
            end
            checks++;
            if (o_cs[d] !== (stop ? 4'd0 : 4'd3)) begin
                errors++;
                $display("FAIL stop_state dut%0d got %0d want %0d", d, o_cs[d], stop ? 0 : 3);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (o_cs[d] !== 4'd0 || o_dout[d] !== 8'h00 || o_valid[d] !== 1'b0 ||
                o_ferr[d] !== 1'b0 || o_match[d] !== 1'b0 || o_cnt[d] !== 8'd0) begin
                errors++;
                $display("FAIL %s dut%0d got cs=%0d dout=%h v=%b fe=%b m=%b cnt=%0d want all 0",
                         tag, d, o_cs[d], o_dout[d], o_valid[d], o_ferr[d], o_match[d], o_cnt[d]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_basic();
        exp_w[0] = 8'hA5;
        exp_w[1] = 8'hA5;
        send_frame(8'hA5, 1'b1, 0);
        idle(1);
        // 8'h01 sent LSB-first: the MSB-first instance sees 8'h80.
        send_frame(8'h80, 1'b1, 0);
        idle(1);
        checks++;
        if (o_cnt[1] !== 8'd2 || o_dout[1] !== 8'h01 || o_match[1] !== 1'b0) begin
            errors++;
            $display("FAIL lsb_first got cnt=%0d dout=%h match=%b want 2 01 0",
                     o_cnt[1], o_dout[1], o_match[1]);
        end
    endtask

    task automatic test_framing_error();
        send_frame(8'h3C, 1'b0, 0);
        for (int k = 0; k < 3; k++) begin
            strobe(1'b0, 3, 1'b1);
            checks++;
            if (o_cs[0] !== 4'd3 || o_cs[1] !== 4'd3) begin
                errors++;
                $display("FAIL resync_hold got %0d/%0d want 3", o_cs[0], o_cs[1]);
            end
        end
        strobe(1'b1, 0, 1'b1);
        checks++;
        if (o_cs[0] !== 4'd0 || o_cs[1] !== 4'd0) begin
            errors++;
            $display("FAIL resync_exit got %0d/%0d want 0", o_cs[0], o_cs[1]);
        end
    endtask

    task automatic test_strobe_gaps();
        exp_w[0] = 8'hA5;
        exp_w[1] = 8'hA5;
        send_frame(8'hA5, 1'b1, 5);
        idle(2);
    endtask

    task automatic test_reset_mid_frame();
        strobe(1'b0, 1, 1'b1);
        for (int k = 0; k < 4; k++) strobe(1'($urandom), 1, 1'b1);
        rst = 1'b1;
        #1;
        check_reset_values("reset_mid_frame");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_w[0] = 8'hFF;
        exp_w[1] = 8'h00;
        send_frame(8'hFF, 1'b1, 1);
        idle(1);
    endtask

    task automatic test_random();
        for (int f = 0; f < 30; f++) begin
            logic [7:0] seq;
            logic       stop;
            seq      = 8'($urandom);
            stop     = ($urandom_range(0, 3) != 0);
            exp_w[0] = $urandom_range(0, 1) ? seq : 8'($urandom);
            exp_w[1] = $urandom_range(0, 1) ? reverse8(seq) : 8'($urandom);
            send_frame(seq, stop, $urandom_range(0, 3));
            if (!stop) begin
                for (int k = $urandom_range(0, 2); k > 0; k--) strobe(1'b0, 3, 1'b1);
                strobe(1'b1, 0, 1'b1);
            end
            // expect changes after the stop edge must not disturb match.
            exp_w[0] = 8'($urandom);
            exp_w[1] = 8'($urandom);
            idle($urandom_range(1, 3));
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (o_match[d] !== md_match[d] || o_cnt[d] !== 8'(md_cnt[d])) begin
                    errors++;
                    $display("FAIL match_hold dut%0d got match=%b cnt=%0d want %b %0d",
                             d, o_match[d], o_cnt[d], md_match[d], md_cnt[d]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        rst = 1'b1;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        vpulses = 0;
        epulses = 0;
        for (int f = 0; f < 256; f++) send_frame(8'($urandom), 1'b1, 0);
        idle(1);
        checks++;
        if (vpulses != 256 || epulses != 0) begin
            errors++;
            $display("FAIL b2b_pulses got valid=%0d ferr=%0d want 256 0", vpulses, epulses);
        end
        checks++;
        if (o_cnt[0] !== 8'd0 || o_cnt[1] !== 8'd0) begin
            errors++;
            $display("FAIL b2b_wrap got %0d/%0d want 0", o_cnt[0], o_cnt[1]);
        end
    endtask

    initial begin
        exp_w = '0;
        test_reset();
        test_basic();
        test_framing_error();
        test_strobe_gaps();
        test_reset_mid_frame();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
